// File: rtl/elevator_pkg.sv
// Shared constants for the elevator call panel.
// Request bit order, floor codes and summary masks.
package elevator_pkg;

  localparam int REQ_W = 7;

  localparam int REQ_F1_UP   = 0;
  localparam int REQ_F2_DOWN = 1;
  localparam int REQ_F2_UP   = 2;
  localparam int REQ_F3_DOWN = 3;
  localparam int REQ_CAR1    = 4;
  localparam int REQ_CAR2    = 5;
  localparam int REQ_CAR3    = 6;

  typedef logic [REQ_W-1:0] req_vec_t;

  localparam logic [2:0] FLOOR_1 = 3'b001;
  localparam logic [2:0] FLOOR_2 = 3'b010;
  localparam logic [2:0] FLOOR_3 = 3'b100;

  // Requests that count as "at" each floor.
  localparam req_vec_t MASK_F1 = 7'b0010001;
  localparam req_vec_t MASK_F2 = 7'b0100110;
  localparam req_vec_t MASK_F3 = 7'b1001000;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/call_debounce.sv
// One button: 2-flop sync, saturating debounce counter,
// armed flag. Emits a one-cycle accept strobe per press.
module call_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic accept
);

  logic [1:0]       sync;
  logic [1:0]       vld;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             armed;
  logic             rls;
  logic             lvl;

  assign lvl = sync[1];

  // Count synchronized-high cycles; strobe on reaching the threshold.
  // rls blocks a button held across reset until a real low is seen.
  always_comb begin
    cnt_nxt = '0;
    if (lvl) begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end
    accept = armed & rls & lvl &
             (cnt_nxt == CNT_W'(DEBOUNCE_CYCLES));
  end

  // Synchronizer, counter and arming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      vld   <= '0;
      cnt   <= '0;
      armed <= 1'b1;
      rls   <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      vld  <= {vld[0], 1'b1};
      cnt  <= cnt_nxt;
      if (!lvl) begin
        armed <= 1'b1;
      end else if (accept) begin
        armed <= 1'b0;
      end
      if (vld[1] && !lvl) begin
        rls <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_call_panel.sv
// Elevator request front end: debounced buttons latch
// pending requests, service clears them, summaries registered.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             floor1_up,
  input  logic             floor2_down,
  input  logic             floor2_up,
  input  logic             floor3_down,
  input  logic             floor1_button,
  input  logic             floor2_button,
  input  logic             floor3_button,
  input  logic             floor_1_indi,
  input  logic             floor_2_indi,
  input  logic             floor_3_indi,
  input  logic             door_open,
  input  logic             dir_up,
  output logic [REQ_W-1:0] req_lamp,
  output logic             req_here,
  output logic             req_above,
  output logic             req_below,
  output logic             any_req
);

  req_vec_t   raw;
  req_vec_t   set;
  req_vec_t   clr;
  req_vec_t   req;
  req_vec_t   req_nxt;
  logic [2:0] floor;
  logic       here_nxt;
  logic       above_nxt;
  logic       below_nxt;

  assign raw = {floor3_button, floor2_button, floor1_button,
                floor3_down, floor2_up, floor2_down, floor1_up};

  assign floor = {floor_3_indi, floor_2_indi, floor_1_indi};

  for (genvar i = 0; i < REQ_W; i++) begin : g_btn
    call_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (raw[i]),
      .accept(set[i])
    );
  end

  // Service clears at the open-door floor; hall direction at floor 2.
  always_comb begin
    clr = '0;
    if (door_open) begin
      case (floor)
        FLOOR_1: begin
          clr[REQ_CAR1]  = 1'b1;
          clr[REQ_F1_UP] = 1'b1;
        end
        FLOOR_2: begin
          clr[REQ_CAR2]    = 1'b1;
          clr[REQ_F2_UP]   = dir_up;
          clr[REQ_F2_DOWN] = ~dir_up;
        end
        FLOOR_3: begin
          clr[REQ_CAR3]    = 1'b1;
          clr[REQ_F3_DOWN] = 1'b1;
        end
        default: clr = '0;
      endcase
    end
  end

  // Clear wins over a same-cycle set.
  assign req_nxt = (req | set) & ~clr;

  // Summaries from the next-state vector; hold when floor unknown.
  always_comb begin
    here_nxt  = req_here;
    above_nxt = req_above;
    below_nxt = req_below;
    case (floor)
      FLOOR_1: begin
        here_nxt  = |(req_nxt & MASK_F1);
        above_nxt = |(req_nxt & ~MASK_F1);
        below_nxt = 1'b0;
      end
      FLOOR_2: begin
        here_nxt  = |(req_nxt & MASK_F2);
        above_nxt = |(req_nxt & MASK_F3);
        below_nxt = |(req_nxt & MASK_F1);
      end
      FLOOR_3: begin
        here_nxt  = |(req_nxt & MASK_F3);
        above_nxt = 1'b0;
        below_nxt = |(req_nxt & ~MASK_F3);
      end
      default: begin
        here_nxt  = req_here;
        above_nxt = req_above;
        below_nxt = req_below;
      end
    endcase
  end

  // Request register and registered summaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req       <= '0;
      req_here  <= 1'b0;
      req_above <= 1'b0;
      req_below <= 1'b0;
      any_req   <= 1'b0;
    end else begin
      req       <= req_nxt;
      req_here  <= here_nxt;
      req_above <= above_nxt;
      req_below <= below_nxt;
      any_req   <= |req_nxt;
    end
  end

  assign req_lamp = req;

endmodule
